// File: rtl/uart_rx_if.sv
// Receive-side bundle between the RX pin/consumer (master) and the receiver (slave).
interface uart_rx_if;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_active;
  logic       rx_frame_err;
  logic [2:0] sm_main;

  modport master (
    output rx_serial,
    input  rx_dv, rx_byte, rx_active, rx_frame_err, sm_main
  );

  modport slave (
    input  rx_serial,
    output rx_dv, rx_byte, rx_active, rx_frame_err, sm_main
  );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver, oversampled by CLKS_PER_BIT, mid-bit sampling, stop-bit check.
// Optional 2-of-3 majority sampling around each sample point when UART_RX_MAJORITY_EN is defined.
//
// state   | meaning
// IDLE    | line idle, waiting for r_rx low
// START   | qualifying start bit at half-bit point
// DATA    | sampling 8 data bits, LSB first
// STOP    | sampling stop bit, strobe DV or frame error
// CLEANUP | wait for line high before re-arming
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  uart_rx_if.slave    bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] H_CNT    = CW'(H);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, r_rx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          dv_q, dv_nxt;
  logic          ferr_q, ferr_nxt;
  logic          smp;

`ifdef UART_RX_MAJORITY_EN
  // The counter advances every cycle, so the last two r_rx values are the target-2/target-1 samples.
  logic [1:0] hist;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) hist <= 2'b11;
    else          hist <= {hist[0], r_rx};
  end

  assign smp = (hist[1] & hist[0]) | (hist[1] & r_rx) | (hist[0] & r_rx);
`else
  assign smp = r_rx;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      r_rx    <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx_serial;
      r_rx    <= rx_meta;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      byte_q  <= byte_nxt;
      dv_q    <= dv_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    byte_nxt  = byte_q;
    dv_nxt    = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!r_rx) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == H_CNT) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = smp ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = smp;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = S_CLEANUP;
          if (smp) begin
            byte_nxt = shift;
            dv_nxt   = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_CLEANUP: begin
        // A line held low (break) must not look like a new start bit.
        cnt_nxt = '0;
        if (r_rx) state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rx_dv        = dv_q;
  assign bus.rx_byte      = byte_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_active    = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign bus.sm_main      = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a line driver that predicts each frame's strobe cycle and byte,
// checked every cycle against the DUT, plus directed and random frames.
module tb_uart_rx;
  localparam int CPB = 87;
  localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic i_Clock = 1'b0;
  logic i_Rst_n = 1'b0;
  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] b;
  } exp_t;

  exp_t       q[$];
  int         dv_cyc_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         run = 1'b0;
  logic [7:0] mbyte = 8'h00;
  int         dv_count = 0;
  int         ferr_count = 0;
  int         last_dv_cyc = -1;
  logic       act_at_dv = 1'b0;
  logic       prev_act_at_dv = 1'b0;
  logic       prev_active = 1'b0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Model: strobe appears 2 sync flops + 1 idle detect + H+1 start + 9 bit periods after the pin falls.
  always @(negedge i_Clock) begin
    if (run) begin
      exp_t e;
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk(1'b0, "missed_strobe", 32'(q[0].cyc), 32'(cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk(bus.rx_dv == !e.err, "dv_strobe", 32'(bus.rx_dv), 32'(!e.err));
        chk(bus.rx_frame_err == e.err, "ferr_strobe", 32'(bus.rx_frame_err), 32'(e.err));
        if (!e.err) mbyte = e.b;
      end else begin
        chk(!bus.rx_dv && !bus.rx_frame_err, "no_strobe",
            {30'd0, bus.rx_dv, bus.rx_frame_err}, 32'd0);
      end
      chk(bus.rx_byte == mbyte, "byte_value", 32'(bus.rx_byte), 32'(mbyte));
      if (bus.rx_dv) begin
        dv_count++;
        last_dv_cyc    = cyc;
        act_at_dv      = bus.rx_active;
        prev_act_at_dv = prev_active;
        dv_cyc_q.push_back(cyc);
      end
      if (bus.rx_frame_err) ferr_count++;
      prev_active = bus.rx_active;
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rx_serial = v;
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop, input bit gl);
    exp_t e;
    int   bi, ph;
    logic v;
    e.cyc = cyc + 4 + H + 9 * CPB;
    e.err = !stop;
    e.b   = (gl && !MAJ) ? ~b : b;
    q.push_back(e);
    for (int k = 0; k < 10 * CPB; k++) begin
      bi = k / CPB;
      ph = k % CPB;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop;
      else              v = b[bi-1];
      if (gl && bi >= 1 && bi <= 8 && ph == H + 1) v = ~v;
      bus.rx_serial = v;
      @(posedge i_Clock);
      #1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, d0, f0, n;
    logic [7:0] rb;
    bit bad;

    bus.rx_serial = 1'b1;
    i_Rst_n = 1'b0;
    repeat (3) @(posedge i_Clock);
    #1;
    chk(bus.rx_dv == 1'b0, "rst_dv", 32'(bus.rx_dv), 32'd0);
    chk(bus.rx_byte == 8'h00, "rst_byte", 32'(bus.rx_byte), 32'h0);
    chk(bus.rx_active == 1'b0, "rst_active", 32'(bus.rx_active), 32'd0);
    chk(bus.rx_frame_err == 1'b0, "rst_ferr", 32'(bus.rx_frame_err), 32'd0);
    chk(bus.sm_main == 3'd0, "rst_state", 32'(bus.sm_main), 32'd0);
    i_Rst_n = 1'b1;
    run = 1'b1;
    hold(1'b1, 20);

    // single frame, literal timing
    p = cyc;
    drive_frame(8'h61, 1'b1, 1'b0);
    hold(1'b1, 10);
    chk(last_dv_cyc == p + 830, "lb_dv_cycle", 32'(last_dv_cyc - p), 32'd830);
    chk(dv_count == 1, "lb_dv_count", 32'(dv_count), 32'd1);
    chk(bus.rx_byte == 8'h61, "lb_byte", 32'(bus.rx_byte), 32'h61);
    chk(ferr_count == 0, "lb_no_ferr", 32'(ferr_count), 32'd0);
    chk(act_at_dv == 1'b0 && prev_act_at_dv == 1'b1, "lb_active_fall",
        {30'd0, prev_act_at_dv, act_at_dv}, 32'b10);

    // back-to-back frames
    d0 = dv_count;
    drive_frame(8'h00, 1'b1, 1'b0);
    drive_frame(8'hFF, 1'b1, 1'b0);
    drive_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 10);
    chk(dv_count == d0 + 3, "b2b_dv_count", 32'(dv_count - d0), 32'd3);
    n = dv_cyc_q.size();
    if (n >= 3) begin
      chk(dv_cyc_q[n-1] - dv_cyc_q[n-2] == 870, "b2b_spacing_2", 32'(dv_cyc_q[n-1] - dv_cyc_q[n-2]), 32'd870);
      chk(dv_cyc_q[n-2] - dv_cyc_q[n-3] == 870, "b2b_spacing_1", 32'(dv_cyc_q[n-2] - dv_cyc_q[n-3]), 32'd870);
    end else begin
      chk(1'b0, "b2b_dv_recorded", 32'(n), 32'd3);
    end
    chk(bus.rx_byte == 8'hA5, "b2b_last_byte", 32'(bus.rx_byte), 32'hA5);

    // glitch shorter than half a bit
    d0 = dv_count;
    f0 = ferr_count;
    hold(1'b0, 10);
    chk(bus.sm_main == 3'd1, "glitch_start_state", 32'(bus.sm_main), 32'd1);
    hold(1'b0, 10);
    hold(1'b1, H + 10);
    chk(bus.sm_main == 3'd0, "glitch_idle_state", 32'(bus.sm_main), 32'd0);
    chk(dv_count == d0 && ferr_count == f0, "glitch_no_strobe", 32'(dv_count - d0 + ferr_count - f0), 32'd0);

    // stop bit low, then break
    f0 = ferr_count;
    d0 = dv_count;
    drive_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 250);
    chk(bus.sm_main == 3'd4, "break_cleanup_mid", 32'(bus.sm_main), 32'd4);
    hold(1'b0, 250);
    chk(bus.sm_main == 3'd4, "break_cleanup_end", 32'(bus.sm_main), 32'd4);
    chk(ferr_count == f0 + 1, "break_ferr_count", 32'(ferr_count - f0), 32'd1);
    chk(bus.rx_byte == 8'hA5, "break_byte_kept", 32'(bus.rx_byte), 32'hA5);
    hold(1'b1, 10);
    chk(bus.sm_main == 3'd0, "break_release_idle", 32'(bus.sm_main), 32'd0);
    hold(1'b1, 200);
    chk(bus.sm_main == 3'd0 && dv_count == d0, "break_no_restart", 32'(bus.sm_main), 32'd0);

    // reset during data bit 4 of 8'h55
    d0 = dv_count;
    rb = 8'h55;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(rb[i], CPB);
    hold(rb[4], 40);
    chk(bus.rx_active == 1'b1, "pre_reset_active", 32'(bus.rx_active), 32'd1);
    i_Rst_n = 1'b0;
    @(posedge i_Clock);
    #1;
    i_Rst_n = 1'b1;
    q.delete();
    mbyte = 8'h00;
    chk(bus.rx_dv == 1'b0 && bus.rx_frame_err == 1'b0, "mid_rst_strobes",
        {30'd0, bus.rx_dv, bus.rx_frame_err}, 32'd0);
    chk(bus.rx_byte == 8'h00, "mid_rst_byte", 32'(bus.rx_byte), 32'h0);
    chk(bus.rx_active == 1'b0, "mid_rst_active", 32'(bus.rx_active), 32'd0);
    chk(bus.sm_main == 3'd0, "mid_rst_state", 32'(bus.sm_main), 32'd0);
    hold(1'b1, 3 * CPB);
    chk(dv_count == d0, "mid_rst_no_dv", 32'(dv_count - d0), 32'd0);
    drive_frame(8'h12, 1'b1, 1'b0);
    hold(1'b1, 10);
    chk(bus.rx_byte == 8'h12 && dv_count == d0 + 1, "post_rst_frame", 32'(bus.rx_byte), 32'h12);

    // one-cycle inverted glitch at every data sample point
    drive_frame(8'hC3, 1'b1, 1'b1);
    hold(1'b1, 10);
    chk(bus.rx_byte == (MAJ ? 8'hC3 : 8'h3C), "sample_glitch_byte", 32'(bus.rx_byte), MAJ ? 32'hC3 : 32'h3C);

    // random frames and gaps
    for (int i = 0; i < 12; i++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      drive_frame(rb, !bad, 1'b0);
      hold(1'b1, bad ? int'($urandom_range(5, 40)) : int'($urandom_range(0, 30)));
    end
    hold(1'b1, 20);
    chk(q.size() == 0, "queue_drained", 32'(q.size()), 32'd0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
